// File: rtl/he_pkg.sv
// he_pkg: shared constants and types for the HE frame sequencer.
// Holds the datapath one-hot state encodings, the LUT size, the default bank
// size and the sequencer state enum.
package he_pkg;

    localparam logic [6:0] HE_IDLE  = 7'b0000001;
    localparam logic [6:0] HE_INIT  = 7'b0000010;
    localparam logic [6:0] HE_HIST1 = 7'b0000100;
    localparam logic [6:0] HE_HIST2 = 7'b0001000;
    localparam logic [6:0] HE_CDF   = 7'b0010000;
    localparam logic [6:0] HE_DST   = 7'b0100000;
    localparam logic [6:0] HE_DONE  = 7'b1000000;

    localparam int HE_MAX_VALUE = 256;
    localparam int HE_MEM_SIZE  = 545920;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_WAIT1,
        S_FEED1,
        S_WAIT2,
        S_FEED2,
        S_WAIT_OUT,
        S_CAPTURE,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/he_strobe_delay.sv
// he_strobe_delay: delays read-enable and bank-select into the datapath strobes.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   flush       clears the pipeline and masks the strobes in the same cycle
//   valid, sel  read enable and bank select as issued to the pixel memory
//   we1, we2    bank 1 / bank 2 pixel-valid strobes, DEPTH cycles after valid
//   pending     a strobe is still in flight
module he_strobe_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic valid,
    input  logic sel,
    output logic we1,
    output logic we2,
    output logic pending
);

    logic [DEPTH-1:0] v, s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
            s <= '0;
        end else if (flush) begin
            v <= '0;
            s <= '0;
        end else begin
            v <= {v[DEPTH-2:0], valid};
            s <= {s[DEPTH-2:0], sel};
        end
    end

    assign we1     = v[DEPTH-1] & ~s[DEPTH-1] & ~flush;
    assign we2     = v[DEPTH-1] &  s[DEPTH-1] & ~flush;
    assign pending = |v;

endmodule

// File: rtl/he_frame_sequencer.sv
// he_frame_sequencer: runs one histogram-equalisation pass of the HE datapath per frame.
// Streams bank 1 then bank 2 into the datapath, then copies the 256-entry LUT
// into an 8-bit remap LUT. Optional watchdog: define HE_SEQ_TIMEOUT_EN.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   frame_start           request one frame (ignored while busy)
//   busy, frame_done      frame in progress / one-cycle completion pulse
//   mem_rd_en, mem_sel,
//   mem_addr              pixel memory read port (sel 0 = bank 1, 1 = bank 2)
//   he_start, he_we1,
//   he_we2                datapath start pulse and per-bank pixel strobes
//   he_state, he_dst      datapath one-hot state and LUT output word
//   lut_wr_en, lut_wr_addr,
//   lut_wr_data           remap LUT write port
//   error                 sticky: LUT clamp, early DONE exit or timeout
module he_frame_sequencer
    import he_pkg::*;
#(
    parameter int AWIDTH    = 21,
    parameter int MEM_SIZE  = HE_MEM_SIZE,
    parameter int MAX_VALUE = HE_MAX_VALUE,
    parameter int RD_LAT    = 1
`ifdef HE_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 2097151
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    output logic              busy,
    output logic              frame_done,
    output logic              mem_rd_en,
    output logic              mem_sel,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              he_start,
    output logic              he_we1,
    output logic              he_we2,
    input  logic [6:0]        he_state,
    input  logic [AWIDTH-1:0] he_dst,
    output logic              lut_wr_en,
    output logic [7:0]        lut_wr_addr,
    output logic [7:0]        lut_wr_data,
    output logic              error
);

    seq_state_t        state, state_next;
    logic [AWIDTH-1:0] addr;
    logic [8:0]        idx;
    logic              seen, match, hist_ok, feed, last, pending;
    logic              lut_wr, clamp, err_set, timeout;

    assign feed  = state == S_FEED1 || state == S_FEED2;
    assign last  = addr == AWIDTH'(MEM_SIZE - 1);
    // The HIST phase must hold two cycles so the datapath counter clear has landed.
    assign match = (state == S_WAIT1 && he_state == HE_HIST1) ||
                   (state == S_WAIT2 && he_state == HE_HIST2);
    assign hist_ok = match && seen;
    assign clamp   = |he_dst[AWIDTH-1:8];
    // idx 0 is the D2 cycle; entries arrive from D3 on.
    assign lut_wr  = state == S_CAPTURE && he_state == HE_DONE && idx != 9'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            addr  <= '0;
            idx   <= '0;
            seen  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_next;
            addr  <= (feed && !last) ? addr + 1'b1 : '0;
            idx   <= (state == S_CAPTURE) ? idx + 9'd1 : '0;
            seen  <= match;
            error <= (state == S_IDLE && frame_start) ? 1'b0 : error | err_set;
        end
    end

    always_comb begin
        state_next = state;
        err_set    = lut_wr && clamp;
        case (state)
            S_IDLE:     if (frame_start) state_next = S_START;
            S_START:    state_next = S_WAIT1;
            S_WAIT1:    if (hist_ok) state_next = S_FEED1;
            S_FEED1:    if (last) state_next = S_WAIT2;
            S_WAIT2:    if (hist_ok && !pending) state_next = S_FEED2;
            S_FEED2:    if (last) state_next = S_WAIT_OUT;
            S_WAIT_OUT: if (he_state == HE_DONE) state_next = S_CAPTURE;
            S_CAPTURE: begin
                if (he_state != HE_DONE) begin
                    err_set    = 1'b1;
                    state_next = S_DONE;
                end else if (idx == 9'(MAX_VALUE)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
        if (timeout) begin
            state_next = S_IDLE;
            err_set    = 1'b1;
        end
    end

`ifdef HE_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd;
    logic          wait_st;

    assign wait_st = state inside {S_WAIT1, S_WAIT2, S_WAIT_OUT, S_CAPTURE};
    assign timeout = wait_st && wd == TW'(TIMEOUT_CYC - 1);

    // Restarts whenever the FSM changes state, so each wait gets its own budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wd <= '0;
        else       wd <= (wait_st && state_next == state) ? wd + 1'b1 : '0;
    end
`else
    assign timeout = 1'b0;
`endif

    he_strobe_delay #(.DEPTH(RD_LAT + 1)) u_strobe (
        .clk     (clk),
        .reset   (reset),
        .flush   (timeout),
        .valid   (mem_rd_en),
        .sel     (mem_sel),
        .we1     (he_we1),
        .we2     (he_we2),
        .pending (pending)
    );

    assign busy        = state != S_IDLE;
    assign frame_done  = state == S_DONE || timeout;
    assign mem_rd_en   = feed;
    assign mem_sel     = state == S_FEED2;
    assign mem_addr    = feed ? addr : '0;
    assign he_start    = state == S_START;
    assign lut_wr_en   = lut_wr;
    assign lut_wr_addr = lut_wr ? idx[7:0] - 8'd1 : '0;
    assign lut_wr_data = lut_wr ? (clamp ? 8'hFF : he_dst[7:0]) : '0;

endmodule

// File: tb/tb_he_frame_sequencer.sv
// tb_he_frame_sequencer: scoreboard bench for he_frame_sequencer with a behavioural datapath.
module tb_he_frame_sequencer;
    import he_pkg::*;

    localparam int AW = 21;
    localparam int MS = 8;

    logic          clk = 1'b0, reset = 1'b1, frame_start = 1'b0;
    logic          busy, frame_done, mem_rd_en, mem_sel, he_start, he_we1, he_we2, lut_wr_en, error;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] he_dst = '0;
    logic [6:0]    he_state = HE_IDLE;
    logic [7:0]    lut_wr_addr, lut_wr_data;
    logic [45:0]   outs;

    assign outs = {busy, frame_done, mem_rd_en, mem_sel, mem_addr, he_start,
                   he_we1, he_we2, lut_wr_en, lut_wr_addr, lut_wr_data, error};

    he_frame_sequencer #(
        .AWIDTH(AW), .MEM_SIZE(MS), .MAX_VALUE(256), .RD_LAT(1)
`ifdef HE_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYC(50)
`endif
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy),
        .frame_done(frame_done), .mem_rd_en(mem_rd_en), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .he_start(he_start), .he_we1(he_we1), .he_we2(he_we2),
        .he_state(he_state), .he_dst(he_dst), .lut_wr_en(lut_wr_en),
        .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data), .error(error)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int phase = 0, pcnt = 0, frame_id = 0, seen_id = 0, clamp_idx = -1;
    int di, dv, ws;
    bit stuck = 1'b0;
    int rd_n[2], we_n[2];
    int lut_n = 0, start_n = 0, done_n = 0, start_cyc = 0, done_cyc = 0;
    int we_q[$], lut_q[$], start_q[$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Datapath model drives just after posedge; scoreboard samples on negedge.
    always begin
        @(posedge clk);
        #1;
        pcnt++;
        he_dst = '0;
        case (phase)
            1:       he_state = HE_INIT;
            2:       he_state = HE_HIST1;
            3:       he_state = HE_HIST2;
            4:       he_state = HE_CDF;
            5:       he_state = HE_DONE;
            default: he_state = HE_IDLE;
        endcase
        if (phase == 5 && pcnt >= 3 && pcnt <= 258) begin
            di = pcnt - 3;
            dv = (di == clamp_idx) ? 300 : di;
            he_dst = AW'(dv);
            lut_q.push_back((di << 8) | (dv > 255 ? 255 : dv));
        end
        @(negedge clk);
        cyc++;
        if (reset || frame_id != seen_id) begin
            seen_id = frame_id;
            phase = 0;
            rd_n = '{0, 0};
            we_n = '{0, 0};
            lut_n = 0;
            start_n = 0;
            done_n = 0;
            we_q.delete();
            lut_q.delete();
            start_q.delete();
        end
        if (!reset) begin
            if (frame_start && !busy) start_q.push_back(cyc + 1);
            if (he_start) begin
                start_n++;
                start_cyc = cyc;
                check("start_lat", cyc, start_q.size() != 0 ? start_q.pop_front() : -1);
                if (phase == 0) begin
                    phase = 1;
                    pcnt = 0;
                end
            end
            if (mem_rd_en) begin
                check("rd_addr", mem_addr, rd_n[int'(mem_sel)]);
                rd_n[int'(mem_sel)]++;
                we_q.push_back((cyc + 2) * 2 + int'(mem_sel));
            end
            if (he_we1 || he_we2) begin
                ws = int'(he_we2);
                check("we_onehot", he_we1 & he_we2, 0);
                check("we_align", cyc * 2 + ws, we_q.size() != 0 ? we_q.pop_front() : -1);
                we_n[ws]++;
            end
            if (lut_wr_en) begin
                lut_n++;
                check("lut_entry", {lut_wr_addr, lut_wr_data}, lut_q.size() != 0 ? lut_q.pop_front() : -1);
            end
            if (frame_done) begin
                done_n++;
                done_cyc = cyc;
                phase = 0;
            end
            if (phase == 1 && !stuck && pcnt >= 3) begin
                phase = 2;
                pcnt = 0;
            end else if (phase == 2 && we_n[0] == MS) begin
                phase = 3;
                pcnt = 0;
            end else if (phase == 3 && we_n[1] == MS) begin
                phase = 4;
                pcnt = 0;
            end else if (phase == 4 && pcnt >= 3) begin
                phase = 5;
                pcnt = 0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    task automatic start_frame();
        frame_id++;
        pulse_start();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && done_n == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("done_pulses", done_n, 1);
        check("busy_after", busy, 0);
    endtask

    task automatic check_frame(bit exp_err);
        check("rd1_cnt", rd_n[0], MS);
        check("rd2_cnt", rd_n[1], MS);
        check("we1_cnt", we_n[0], MS);
        check("we2_cnt", we_n[1], MS);
        check("lut_cnt", lut_n, 256);
        check("start_cnt", start_n, 1);
        check("we_q_left", we_q.size(), 0);
        check("lut_q_left", lut_q.size(), 0);
        check("error", error, exp_err);
    endtask

    initial begin
        int hit;
        repeat (2) @(negedge clk);
        check("reset_outs", outs, 0);
        @(posedge clk);
        #1 reset = 1'b0;
`ifndef HE_SEQ_TIMEOUT_EN
        clamp_idx = -1;
        start_frame();
        wait_done();
        check_frame(1'b0);

        clamp_idx = 5;
        start_frame();
        wait_done();
        check_frame(1'b1);
        repeat (5) @(negedge clk);
        check("err_sticky", error, 1);

        clamp_idx = -1;
        start_frame();
        @(negedge clk);
        check("err_clear", error, 0);
        wait_done();
        check_frame(1'b0);

        start_frame();
        hit = 0;
        for (int i = 0; i < 200 && hit == 0; i++) begin
            @(negedge clk);
            if (mem_rd_en && !mem_sel && mem_addr == 3) hit = 1;
        end
        check("feed1_addr3", hit, 1);
        #2 reset = 1'b1;
        @(negedge clk);
        check("midframe_rst_outs", outs, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        start_frame();
        wait_done();
        check_frame(1'b0);

        start_frame();
        hit = 0;
        for (int i = 0; i < 200 && hit == 0; i++) begin
            @(negedge clk);
            if (mem_rd_en && mem_sel) hit = 1;
        end
        check("feed2_seen", hit, 1);
        pulse_start();
        wait_done();
        check_frame(1'b0);
`else
        stuck = 1'b1;
        start_frame();
        wait_done();
        check("to_done_cyc", done_cyc, start_cyc + 50);
        check("to_error", error, 1);
        check("to_we1", we_n[0], 0);
        check("to_rd", rd_n[0], 0);
        check("to_start_cnt", start_n, 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
